// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the register-file write port between core writeback and a
//            FIFO of CGRA results. Core has priority, with starvation relief.
//            Optional macro REGARB_STATS_EN adds saturating statistic outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk_i,
    input  logic                     reset,
    input  logic                     core_we_i,
    input  logic [4:0]               core_rd_i,
    input  logic [31:0]              core_data_i,
    input  logic [3:0]               core_pos_i,
    output logic                     core_stall_o,
    input  logic                     cgra_valid_i,
    output logic                     cgra_ready_o,
    input  logic [4:0]               cgra_rd_i,
    input  logic [31:0]              cgra_data_i,
    input  logic [3:0]               cgra_pos_i,
    output logic                     RegWrite_o,
    output logic [4:0]               RDaddr_o,
    output logic [31:0]              RDdata_o,
    output logic [3:0]               is_pos_o,
    output logic [31:0]              pend_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
`ifdef REGARB_STATS_EN
    ,
    output logic [15:0]              stat_core_o,
    output logic [15:0]              stat_cgra_o,
    output logic [15:0]              stat_squash_o,
    output logic [15:0]              stat_stall_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_dat  [DEPTH];
    logic [3:0]       r_ps   [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_cnt;
    logic             r_stall;
    logic             r_we;
    logic [4:0]       r_addr;
    logic [31:0]      r_data;
    logic [3:0]       r_pos;

    logic             w_ready;
    logic             w_head_occ;
    logic             w_any_vld;
    logic             w_core_grant;
    logic             w_pop;
    logic             w_head_wr;
    logic             w_push;
    logic [SW-1:0]    w_cnt_inc;
    logic [DEPTH-1:0] w_vld_next;
    logic [31:0]      w_pend;

    assign w_ready      = (r_count < CW'(DEPTH));
    assign w_head_occ   = (r_count != '0);
    assign w_any_vld    = |r_vld;
    // During the stall cycle the core is never granted, even with nothing to drain.
    assign w_core_grant = !r_stall && core_we_i;
    assign w_pop        = w_head_occ && (r_stall || !core_we_i);
    assign w_head_wr    = w_pop && r_vld[r_rptr];
    assign w_push       = cgra_valid_i && w_ready && (cgra_rd_i != 5'd0);
    assign w_cnt_inc    = r_cnt + SW'(1);

    // Squash precedes the push so a same-cycle CGRA result for the same rd stays valid.
    always_comb begin
        w_vld_next = r_vld;
        if (w_core_grant && (core_rd_i != 5'd0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_rd[i] == core_rd_i) begin
                    w_vld_next[i] = 1'b0;
                end
            end
        end
        if (w_pop) begin
            w_vld_next[r_rptr] = 1'b0;
        end
        if (w_push) begin
            w_vld_next[r_wptr] = 1'b1;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pend[r_rd[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_cnt   <= '0;
            r_stall <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_pos   <= '0;
        end else begin
            if (w_push) begin
                r_rd[r_wptr]  <= cgra_rd_i;
                r_dat[r_wptr] <= cgra_data_i;
                r_ps[r_wptr]  <= cgra_pos_i;
            end
            r_vld   <= w_vld_next;
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            if (w_core_grant) begin
                r_we   <= (core_rd_i != 5'd0);
                r_addr <= core_rd_i;
                r_data <= core_data_i;
                r_pos  <= core_pos_i;
            end else if (w_head_wr) begin
                r_we   <= 1'b1;
                r_addr <= r_rd[r_rptr];
                r_data <= r_dat[r_rptr];
                r_pos  <= r_ps[r_rptr];
            end else begin
                r_we   <= 1'b0;
            end

            if (w_core_grant && w_any_vld) begin
                if (w_cnt_inc == SW'(STARVE_MAX)) begin
                    r_cnt   <= '0;
                    r_stall <= 1'b1;
                end else begin
                    r_cnt   <= w_cnt_inc;
                    r_stall <= 1'b0;
                end
            end else begin
                r_cnt   <= '0;
                r_stall <= 1'b0;
            end
        end
    end

    assign core_stall_o = r_stall;
    assign cgra_ready_o = w_ready;
    assign RegWrite_o   = r_we;
    assign RDaddr_o     = r_addr;
    assign RDdata_o     = r_data;
    assign is_pos_o     = r_pos;
    assign pend_o       = w_pend;
    assign fifo_count_o = r_count;

`ifdef REGARB_STATS_EN
    logic [15:0] r_st_core;
    logic [15:0] r_st_cgra;
    logic [15:0] r_st_squash;
    logic [15:0] r_st_stall;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_st_core   <= '0;
            r_st_cgra   <= '0;
            r_st_squash <= '0;
            r_st_stall  <= '0;
        end else begin
            if (w_core_grant && (core_rd_i != 5'd0) && (r_st_core != 16'hFFFF)) begin
                r_st_core <= r_st_core + 16'd1;
            end
            if (w_head_wr && (r_st_cgra != 16'hFFFF)) begin
                r_st_cgra <= r_st_cgra + 16'd1;
            end
            if (w_pop && !r_vld[r_rptr] && (r_st_squash != 16'hFFFF)) begin
                r_st_squash <= r_st_squash + 16'd1;
            end
            if (r_stall && (r_st_stall != 16'hFFFF)) begin
                r_st_stall <= r_st_stall + 16'd1;
            end
        end
    end

    assign stat_core_o   = r_st_core;
    assign stat_cgra_o   = r_st_cgra;
    assign stat_squash_o = r_st_squash;
    assign stat_stall_o  = r_st_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed scoreboard bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  p;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        core_we_i;
    logic [4:0]  core_rd_i;
    logic [31:0] core_data_i;
    logic [3:0]  core_pos_i;
    logic        core_stall_o;
    logic        cgra_valid_i;
    logic        cgra_ready_o;
    logic [4:0]  cgra_rd_i;
    logic [31:0] cgra_data_i;
    logic [3:0]  cgra_pos_i;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [3:0]  is_pos_o;
    logic [31:0] pend_o;
    logic [2:0]  fifo_count_o;

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t sb[$];

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .core_we_i    (core_we_i),
        .core_rd_i    (core_rd_i),
        .core_data_i  (core_data_i),
        .core_pos_i   (core_pos_i),
        .core_stall_o (core_stall_o),
        .cgra_valid_i (cgra_valid_i),
        .cgra_ready_o (cgra_ready_o),
        .cgra_rd_i    (cgra_rd_i),
        .cgra_data_i  (cgra_data_i),
        .cgra_pos_i   (cgra_pos_i),
        .RegWrite_o   (RegWrite_o),
        .RDaddr_o     (RDaddr_o),
        .RDdata_o     (RDdata_o),
        .is_pos_o     (is_pos_o),
        .pend_o       (pend_o),
        .fifo_count_o (fifo_count_o)
    );

    function automatic wr_t mk(input int a, input int d, input int p);
        wr_t w;
        w.a = 5'(a);
        w.d = 32'(d);
        w.p = 4'(p);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        core_we_i    = 1'b0;
        core_rd_i    = '0;
        core_data_i  = '0;
        core_pos_i   = '0;
        cgra_valid_i = 1'b0;
        cgra_rd_i    = '0;
        cgra_data_i  = '0;
        cgra_pos_i   = '0;
    endtask

    task automatic drive_core(input int idx);
        core_we_i   = 1'b1;
        core_rd_i   = 5'(16 + (idx % 8));
        core_data_i = 32'h0000_C000 + 32'(idx);
        core_pos_i  = 4'(idx);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_we"},    32'(RegWrite_o),   32'd0);
        chk({pfx, "_addr"},  32'(RDaddr_o),     32'd0);
        chk({pfx, "_data"},  RDdata_o,          32'd0);
        chk({pfx, "_pos"},   32'(is_pos_o),     32'd0);
        chk({pfx, "_stall"}, 32'(core_stall_o), 32'd0);
        chk({pfx, "_pend"},  pend_o,            32'd0);
        chk({pfx, "_count"}, 32'(fifo_count_o), 32'd0);
        chk({pfx, "_ready"}, 32'(cgra_ready_o), 32'd1);
    endtask

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (RegWrite_o === 1'b1) begin
            wr_t exp_w;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL wr_unexpected: observed addr=%0d data=%h expected no write", RDaddr_o, RDdata_o);
            end
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                n_checks++;
                assert ({RDaddr_o, RDdata_o, is_pos_o} === exp_w) else begin
                    n_errors++;
                    $error("FAIL wr_data: observed addr=%0d data=%h pos=%0d expected addr=%0d data=%h pos=%0d",
                           RDaddr_o, RDdata_o, is_pos_o, exp_w.a, exp_w.d, exp_w.p);
                end
            end
        end
    end

    initial begin
        int  ci;
        int  cj;
        int  hd;
        logic acc;
        bit  stall_cyc;

        reset = 1'b1;
        idle();
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;

        // Single core write, one-cycle latency
        core_we_i   = 1'b1;
        core_rd_i   = 5'd5;
        core_data_i = 32'h0000_1234;
        core_pos_i  = 4'd3;
        sb.push_back(mk(5, 32'h1234, 3));
        tick();
        chk("core_we",   32'(RegWrite_o), 32'd1);
        chk("core_addr", 32'(RDaddr_o),   32'd5);
        chk("core_data", RDdata_o,        32'h0000_1234);
        chk("core_pos",  32'(is_pos_o),   32'd3);
        core_we_i = 1'b0;
        tick();
        chk("core_we_off", 32'(RegWrite_o), 32'd0);

        // CGRA stream with idle core drains one per cycle
        for (int k = 1; k <= 4; k++) begin
            cgra_valid_i = 1'b1;
            cgra_rd_i    = 5'(k);
            cgra_data_i  = 32'h0000_B000 + 32'(k);
            cgra_pos_i   = 4'(k);
            chk("stream_ready", 32'(cgra_ready_o), 32'd1);
            sb.push_back(mk(k, 32'hB000 + k, k));
            tick();
            chk("stream_count", 32'(fifo_count_o), 32'd1);
            chk("stream_pend", pend_o, 32'd1 << k);
        end
        cgra_valid_i = 1'b0;
        tick();
        chk("stream_count_end", 32'(fifo_count_o), 32'd0);
        tick();
        chk("stream_pend_end", pend_o, 32'd0);
        chk("stream_we_end", 32'(RegWrite_o), 32'd0);

        // Starvation: core always requesting, five CGRA results queued behind it
        ci = 0;
        cj = 1;
        hd = 1;
        for (int n = 1; n <= 46; n++) begin
            drive_core(ci);
            cgra_valid_i = (cj <= 5);
            cgra_rd_i    = 5'(cj);
            cgra_data_i  = 32'h0000_A000 + 32'(cj);
            cgra_pos_i   = 4'(cj);
            if (n == 5) begin
                chk("starve_full_ready", 32'(cgra_ready_o), 32'd0);
                chk("starve_full_count", 32'(fifo_count_o), 32'd4);
            end
            stall_cyc = (n > 1) && (n % 9 == 1);
            if (stall_cyc) begin
                chk("starve_stall_on", 32'(core_stall_o), 32'd1);
                sb.push_back(mk(hd, 32'hA000 + hd, hd));
                hd++;
            end else begin
                chk("starve_stall_off", 32'(core_stall_o), 32'd0);
                sb.push_back(mk(16 + (ci % 8), 32'hC000 + ci, ci % 16));
            end
            acc = cgra_valid_i && cgra_ready_o;
            tick();
            if (acc) cj++;
            if (!stall_cyc) ci++;
        end
        idle();
        chk("starve_count_end", 32'(fifo_count_o), 32'd0);
        chk("starve_pend_end", pend_o, 32'd0);
        tick();

        // Core write to a register with a queued CGRA result squashes that entry
        core_we_i    = 1'b1;
        core_rd_i    = 5'd9;
        core_data_i  = 32'h99;
        core_pos_i   = 4'd1;
        cgra_valid_i = 1'b1;
        cgra_rd_i    = 5'd7;
        cgra_data_i  = 32'hAA;
        cgra_pos_i   = 4'd2;
        sb.push_back(mk(9, 32'h99, 1));
        tick();
        chk("squash_pend_set", pend_o, 32'h0000_0080);
        chk("squash_count1", 32'(fifo_count_o), 32'd1);
        cgra_valid_i = 1'b0;
        core_rd_i    = 5'd7;
        core_data_i  = 32'hBB;
        core_pos_i   = 4'd4;
        sb.push_back(mk(7, 32'hBB, 4));
        tick();
        chk("squash_pend_clr", pend_o, 32'd0);
        chk("squash_count_kept", 32'(fifo_count_o), 32'd1);
        core_we_i = 1'b0;
        tick();
        chk("squash_popped", 32'(fifo_count_o), 32'd0);
        chk("squash_no_write", 32'(RegWrite_o), 32'd0);

        // Same-cycle core and CGRA to one register: CGRA value is newer
        core_we_i    = 1'b1;
        core_rd_i    = 5'd3;
        core_data_i  = 32'h33;
        core_pos_i   = 4'd5;
        cgra_valid_i = 1'b1;
        cgra_rd_i    = 5'd3;
        cgra_data_i  = 32'h44;
        cgra_pos_i   = 4'd6;
        sb.push_back(mk(3, 32'h33, 5));
        sb.push_back(mk(3, 32'h44, 6));
        tick();
        chk("samecyc_pend", pend_o, 32'h0000_0008);
        idle();
        tick();
        chk("samecyc_data", RDdata_o, 32'h44);
        chk("samecyc_count", 32'(fifo_count_o), 32'd0);
        tick();

        // x0 from both sources
        core_we_i    = 1'b1;
        core_rd_i    = 5'd0;
        core_data_i  = 32'h66;
        cgra_valid_i = 1'b1;
        cgra_rd_i    = 5'd0;
        cgra_data_i  = 32'h55;
        chk("x0_ready", 32'(cgra_ready_o), 32'd1);
        tick();
        chk("x0_we", 32'(RegWrite_o), 32'd0);
        chk("x0_count", 32'(fifo_count_o), 32'd0);
        chk("x0_pend", pend_o, 32'd0);
        idle();
        tick();
        chk("x0_we_after", 32'(RegWrite_o), 32'd0);

        // Reset while three entries are queued and the core is stalled
        ci = 0;
        for (int n = 1; n <= 9; n++) begin
            drive_core(ci);
            cgra_valid_i = (n <= 3);
            cgra_rd_i    = 5'(10 + n);
            cgra_data_i  = 32'h0000_D000 + 32'(n);
            cgra_pos_i   = 4'(n);
            sb.push_back(mk(16 + (ci % 8), 32'hC000 + ci, ci % 16));
            tick();
            ci++;
        end
        chk("rst_pre_stall", 32'(core_stall_o), 32'd1);
        chk("rst_pre_count", 32'(fifo_count_o), 32'd3);
        chk("rst_pre_pend", pend_o, 32'h0000_3800);
        reset = 1'b1;
        idle();
        tick();
        chk_zero("rst_mid");
        reset = 1'b0;
        tick();
        tick();
        chk("rst_after_we", 32'(RegWrite_o), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
